data_sampler: RTL and testbench

Serial-to-parallel capture block for the FPGA modulator. After reset it waits a fixed start-up interval, then samples the serial input `Data` once per sample period. It assembles `WIDTH` bits MSB-first into a register, then freezes the result on `countCtrl` until the next reset. Downstream modulator control logic uses the captured byte as its count/control word.

---
 rtl/modulador_pkg.sv | 18 +
 rtl/data_sampler_if.sv | 14 +
 rtl/data_sampler_timer.sv | 27 ++
 rtl/data_sampler.sv | 76 +++++++
 tb/tb_data_sampler.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/modulador_pkg.sv
// Shared types and default constants for the modulator front-end blocks.
package modulador_pkg;

  typedef enum logic [1:0] {
    WAIT,
    SHIFT,
    DONE
  } sampler_state_t;

  localparam int SAMPLER_WIDTH = 8;
  localparam int SAMPLER_START = 13;
  localparam int SAMPLER_DIV   = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/data_sampler_if.sv
// Serial input / captured word bundle between the sampler and its user.
interface data_sampler_if
  import modulador_pkg::*;
#(
  parameter int WIDTH = SAMPLER_WIDTH
);

  logic             Data;
  logic [WIDTH-1:0] countCtrl;

  modport master (output Data, input countCtrl);
  modport slave  (input Data, output countCtrl);

endinterface

// File: rtl/data_sampler_timer.sv
// Period timer: emits a one-cycle tick every tc enabled edges, restarting when disabled.
module sample_timer #(
  parameter int TC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [TC_W-1:0] tc,
  output logic            tick
);

  logic [TC_W-1:0] cnt;

  assign tick = en && (cnt == tc - TC_W'(1));

  // The counter clears on its own tick so a new terminal count applies from the next period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TC_W'(1);
    end
  end

endmodule

// File: rtl/data_sampler.sv
// Serial-to-parallel capture: start-up delay, WIDTH MSB-first samples, then hold until reset.
module data_sampler
  import modulador_pkg::*;
#(
  parameter int START_CYCLES = SAMPLER_START,
  parameter int SAMPLE_DIV   = SAMPLER_DIV,
  parameter int WIDTH        = SAMPLER_WIDTH
) (
  input logic           clk,
  input logic           rst,
  data_sampler_if.slave bus
);

  // A zero start delay behaves like one edge; the divider is clamped the same way.
  localparam int START_EFF = (START_CYCLES < 1) ? 1 : START_CYCLES;
  localparam int DIV_EFF   = (SAMPLE_DIV < 1) ? 1 : SAMPLE_DIV;
  localparam int TC_W      = $clog2(max_int(START_EFF, DIV_EFF) + 1);
  localparam int BC_W      = $clog2(WIDTH) + 1;

  sampler_state_t   state, next_state;
  logic             timer_en;
  logic [TC_W-1:0]  tc;
  logic             tick;
  logic             sample;
  logic [BC_W-1:0]  bit_cnt;
  logic [WIDTH-1:0] shift_reg;

  sample_timer #(.TC_W(TC_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (timer_en),
    .tc   (tc),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT;
    end else begin
      state <= next_state;
    end
  end

  // Sample 0 is taken on the start-up tick itself; bit_cnt counts samples already taken.
  always_comb begin
    next_state = state;
    timer_en   = 1'b0;
    tc         = TC_W'(START_EFF);
    sample     = 1'b0;
    case (state)
      WAIT, SHIFT: begin
        timer_en = 1'b1;
        tc       = (state == WAIT) ? TC_W'(START_EFF) : TC_W'(DIV_EFF);
        if (tick) begin
          sample     = 1'b1;
          next_state = (bit_cnt == BC_W'(WIDTH - 1)) ? DONE : SHIFT;
        end
      end
      DONE:    next_state = DONE;
      default: next_state = WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (sample) begin
      shift_reg <= (shift_reg << 1) | WIDTH'(bus.Data);
      bit_cnt   <= bit_cnt + BC_W'(1);
    end
  end

  assign bus.countCtrl = shift_reg;

endmodule

// File: tb/tb_data_sampler.sv
// Directed bench for data_sampler: default timing plus a START=4 / DIV=2 instance.
`timescale 1ns/1ps
module tb_data_sampler;

  logic clk = 1'b0;
  logic rst;
  logic rst_div;

  int errors = 0;
  int checks = 0;

  data_sampler_if #(.WIDTH(8)) bus ();
  data_sampler_if #(.WIDTH(8)) bus_div ();

  data_sampler #(.START_CYCLES(13), .SAMPLE_DIV(1), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  data_sampler #(.START_CYCLES(4), .SAMPLE_DIV(2), .WIDTH(8)) dut_div (
    .clk (clk),
    .rst (rst_div),
    .bus (bus_div.slave)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
    end
  endtask

  // Drive Data well before the next rising edge, then settle just after it.
  task automatic applyStimulus(input logic d);
    bus.Data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic restartDut();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] expected;
    logic [7:0] pattern;
    logic       d;

    rst          = 1'b1;
    rst_div      = 1'b1;
    bus.Data     = 1'b0;
    bus_div.Data = 1'b0;

    for (int i = 0; i < 4; i++) begin
      bus.Data = i[0];
      @(posedge clk);
      #1;
      checkOutput("reset_hold", bus.countCtrl, 8'h00);
    end

    // Constant ones from release: nothing before edge 13, then fill from the LSB.
    bus.Data = 1'b1;
    rst      = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(1'b1);
      checkOutput("pre_start", bus.countCtrl, 8'h00);
    end
    expected = 8'h00;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1);
      expected = {expected[6:0], 1'b1};
      checkOutput("const_ones", bus.countCtrl, expected);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0);
      checkOutput("const_hold", bus.countCtrl, 8'hFF);
    end

    rst = 1'b1;
    #1;
    checkOutput("async_clear_done", bus.countCtrl, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    pattern = 8'h9C;
    repeat (12) applyStimulus(1'b1);
    checkOutput("pattern_pre", bus.countCtrl, 8'h00);
    expected = 8'h00;
    for (int k = 7; k >= 0; k--) begin
      applyStimulus(pattern[k]);
      expected = {expected[6:0], pattern[k]};
      checkOutput("pattern_9c", bus.countCtrl, expected);
    end
    for (int i = 0; i < 50; i++) begin
      applyStimulus(i[0]);
      checkOutput("done_hold", bus.countCtrl, 8'h9C);
    end

    restartDut();
    repeat (12) applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("partial_3bits", bus.countCtrl, 8'h04);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("mid_reset_clear", bus.countCtrl, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pattern = 8'h55;
    repeat (12) applyStimulus(1'b1);
    for (int k = 7; k >= 0; k--) applyStimulus(pattern[k]);
    checkOutput("restart_55", bus.countCtrl, 8'h55);
    applyStimulus(1'b1);
    checkOutput("restart_55_hold", bus.countCtrl, 8'h55);

    // Divider instance: samples on edges 4,6,..,18; odd edges carry the inverted bit.
    pattern  = 8'hCA;
    expected = 8'h00;
    rst_div  = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      if (e >= 4 && ((e - 4) % 2) == 0) d = pattern[7 - (e - 4) / 2];
      else if (e >= 4)                  d = ~pattern[7 - (e - 4) / 2];
      else                              d = 1'b1;
      bus_div.Data = d;
      @(posedge clk);
      #1;
      if (e >= 4 && ((e - 4) % 2) == 0) expected = {expected[6:0], d};
      checkOutput("div_step", bus_div.countCtrl, expected);
    end
    checkOutput("div_final_ca", bus_div.countCtrl, 8'hCA);
    for (int i = 0; i < 4; i++) begin
      bus_div.Data = i[0];
      @(posedge clk);
      #1;
      checkOutput("div_hold", bus_div.countCtrl, 8'hCA);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
